eth_udp_rx_sink: RTL and testbench
==================================

Name: eth_udp_rx_sink

Overview:
- Receive-side counterpart of the UDP send controller: consumes the payload stream from udp_ip_mac_top (udp_rec_data_valid / udp_rec_rdata / udp_rec_data_length).
- Stores each datagram in an internal store-and-forward byte buffer.
- Releases only complete, length-checked packets to the application through a length-qualified read port; malformed or non-fitting packets are dropped and counted.

Parameters:
- ADDR_WIDTH, 11, log2 of payload buffer depth in bytes (default 2048).
- MAX_PKT_LEN, 16'd1472, largest accepted payload length.
- LEN_FIFO_DEPTH, 4, number of committed packet descriptors held (power of 2).

Ports:
- rgmii_clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- udp_rec_data_valid  in  1  payload byte strobe; one contiguous high burst per datagram.
- udp_rec_rdata  in  8  payload byte.
- udp_rec_data_length  in  16  payload byte count; stable while valid is high.
- rd_pkt_avail  out  1  at least one committed packet is ready.
- rd_pkt_len  out  16  payload length of the head packet; valid while rd_pkt_avail=1.
- rd_en  in  1  read-one-byte request.
- rd_data  out  8  read byte.
- rd_data_valid  out  1  rd_data qualifier.
- rd_last  out  1  marks the final byte of the packet, with rd_data_valid.
- pkt_ok_cnt  out  16  packets committed, saturating.
- pkt_drop_cnt  out  16  packets dropped, saturating.

Behaviour:
- Reset values: all outputs 0; all pointers, counters and the descriptor FIFO cleared. Reset mid-packet discards the partial packet and any stored packets.
- Pointers are ADDR_WIDTH+1 bits: wr_ptr, commit_ptr, rd_ptr.
  - free = 2^ADDR_WIDTH - (commit_ptr - rd_ptr).
  - Buffer addresses wrap naturally.
- Write FSM states: W_IDLE, W_DATA, W_DROP.
  - W_IDLE, first valid byte: latch len = udp_rec_data_length.
    - Drop (to W_DROP, drop_cnt+1) if len==0, len>MAX_PKT_LEN, len>free, or the descriptor FIFO is full.
    - Otherwise write the byte at wr_ptr, set wr_cnt=1, go to W_DATA.
  - W_DATA, valid=1:
    - If wr_cnt==len (excess byte): rewind wr_ptr<=commit_ptr, drop_cnt+1, go to W_DROP.
    - Otherwise write the byte, increment wr_ptr and wr_cnt.
  - W_DATA, valid=0 (end of burst):
    - If wr_cnt==len: commit. commit_ptr<=wr_ptr, push len to the descriptor FIFO, ok_cnt+1.
    - Else (short): wr_ptr<=commit_ptr, drop_cnt+1.
    - In both cases go to W_IDLE.
  - W_DROP: ignore bytes; return to W_IDLE on the first valid=0 cycle.
  - Back-to-back bursts need at least one valid=0 cycle between them; the stack guarantees this.
- Commit latency: rd_pkt_avail rises on the cycle after the valid=0 cycle that commits, if the FIFO was empty.
- Read side:
  - rd_pkt_avail = descriptor FIFO not empty; rd_pkt_len = FIFO head.
  - rd_en is ignored when rd_pkt_avail=0.
  - Accepted rd_en reads buffer[rd_ptr] (RAM, 1-cycle latency) and increments rd_ptr and rd_rem.
  - rd_data_valid follows an accepted rd_en by exactly 1 cycle.
  - rd_last is asserted with the byte where rd_rem reaches rd_pkt_len.
  - On the cycle the last byte is requested:
    - Pop the descriptor and ignore further rd_en that cycle.
    - rd_pkt_avail is low for at least one cycle (the cycle after the pop).
    - rd_pkt_avail reasserts the following cycle if more packets are pending.
  - Space freed by reads is visible to the free check from the next cycle.
- Commit (push) and pop in the same cycle are both honoured; FIFO occupancy is unchanged.
- Counters saturate at 16'hFFFF; they do not wrap.

Test Plan:
- 20-byte packet "www.meyesemi.com   \n", len=20 -> rd_pkt_avail=1 with rd_pkt_len=20 one cycle after valid falls; 20 rd_en return bytes 0x77..0x0A in order, rd_last on the 20th byte only; pkt_ok_cnt=1.
- len=20 with only 15 bytes sent -> no rd_pkt_avail, pkt_drop_cnt=1; a following 20-byte packet is accepted and read back intact, proving space was restored.
- len=21 with 22 bytes sent -> dropped at the 22nd byte, pkt_drop_cnt=1; len=0 -> dropped; len=1473 -> dropped; rd_pkt_avail stays 0 throughout.
- ADDR_WIDTH=6: three 20-byte packets accepted (60 B); a fourth 20-byte packet is dropped for space; read one packet, resend the fourth -> accepted, and its data is correct across the address wrap at 64.
- Five 8-byte packets back-to-back, no reads -> four committed, fifth dropped (descriptor FIFO full); then read all four concurrently with a new incoming packet -> the same-cycle push/pop keeps the count correct.
- Assert rst mid-burst with two packets stored -> all outputs 0; the next packet is committed from pointer 0; the counters restart.

Source files
------------

// File: rtl/eth_udp_rx_sink_if.sv
// Payload-in and packet-read signal bundle for eth_udp_rx_sink.
// The master modport is the surrounding system; the slave modport is the sink.
interface eth_udp_rx_sink_if;
  logic        udp_rec_data_valid;
  logic [7:0]  udp_rec_rdata;
  logic [15:0] udp_rec_data_length;
  logic        rd_pkt_avail;
  logic [15:0] rd_pkt_len;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_data_valid;
  logic        rd_last;

  modport master (
    output udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, rd_en,
    input  rd_pkt_avail, rd_pkt_len, rd_data, rd_data_valid, rd_last
  );

  modport slave (
    input  udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, rd_en,
    output rd_pkt_avail, rd_pkt_len, rd_data, rd_data_valid, rd_last
  );
endinterface

// File: rtl/eth_udp_rx_sink.sv
// Store-and-forward UDP payload sink: buffers each datagram, commits only
// complete length-checked packets, and hands them out through a byte read port.
module eth_udp_rx_sink #(
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter logic [15:0] MAX_PKT_LEN    = 16'd1472,
  parameter int unsigned LEN_FIFO_DEPTH = 4
) (
  input  logic                    rgmii_clk,
  input  logic                    rst,
  eth_udp_rx_sink_if.slave        bus,
  output logic [15:0]             pkt_ok_cnt,
  output logic [15:0]             pkt_drop_cnt
);

  localparam int unsigned BUF_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LFW       = $clog2(LEN_FIFO_DEPTH);

  typedef logic [ADDR_WIDTH:0] ptr_t;
  typedef logic [LFW:0]        fptr_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_DROP} wr_state_e;

  wr_state_e   state_q, state_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        commit_ptr_q, commit_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  logic [15:0] len_q, len_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  fptr_t       fifo_wp_q, fifo_wp_d;
  fptr_t       fifo_rp_q, fifo_rp_d;
  logic [15:0] rd_rem_q, rd_rem_d;
  logic        blank_q, blank_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_data_valid_q, rd_data_valid_d;
  logic        rd_last_q, rd_last_d;
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic [7:0]  buf_mem  [BUF_DEPTH];
  logic [15:0] len_fifo [LEN_FIFO_DEPTH];

  logic        buf_we, fifo_push, fifo_pop;
  logic        ok_inc, drop_inc;
  logic        fifo_full, fifo_empty;
  ptr_t        occupancy;
  logic [31:0] free_bytes;
  logic [15:0] head_len;
  logic        pkt_avail, rd_accept, rd_final, reject_new;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Space is measured against committed data only, so an in-flight packet
  // never blocks the check and a rewind simply returns its bytes.
  assign occupancy  = commit_ptr_q - rd_ptr_q;
  assign free_bytes = 32'(BUF_DEPTH) - 32'(occupancy);
  assign fifo_empty = (fifo_wp_q == fifo_rp_q);
  assign fifo_full  = (fifo_wp_q[LFW] != fifo_rp_q[LFW]) &&
                      (fifo_wp_q[LFW-1:0] == fifo_rp_q[LFW-1:0]);
  assign head_len   = len_fifo[fifo_rp_q[LFW-1:0]];

  assign reject_new = (bus.udp_rec_data_length == 16'd0) ||
                      (bus.udp_rec_data_length > MAX_PKT_LEN) ||
                      (32'(bus.udp_rec_data_length) > free_bytes) ||
                      fifo_full;

  // The cycle after a pop is blanked so the application sees a clean
  // packet boundary before the next descriptor is offered.
  assign pkt_avail = !fifo_empty && !blank_q;
  assign rd_accept = bus.rd_en && pkt_avail;
  assign rd_final  = rd_accept && ((rd_rem_q + 16'd1) == head_len);
  assign fifo_pop  = rd_final;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    len_d        = len_q;
    wr_cnt_d     = wr_cnt_q;
    buf_we       = 1'b0;
    fifo_push    = 1'b0;
    ok_inc       = 1'b0;
    drop_inc     = 1'b0;

    unique case (state_q)
      W_IDLE: begin
        if (bus.udp_rec_data_valid) begin
          len_d = bus.udp_rec_data_length;
          if (reject_new) begin
            drop_inc = 1'b1;
            state_d  = W_DROP;
          end else begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
            wr_cnt_d = 16'd1;
            state_d  = W_DATA;
          end
        end
      end
      W_DATA: begin
        if (bus.udp_rec_data_valid) begin
          if (wr_cnt_q == len_q) begin
            wr_ptr_d = commit_ptr_q;
            drop_inc = 1'b1;
            state_d  = W_DROP;
          end else begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
            wr_cnt_d = wr_cnt_q + 16'd1;
          end
        end else begin
          if (wr_cnt_q == len_q) begin
            commit_ptr_d = wr_ptr_q;
            fifo_push    = 1'b1;
            ok_inc       = 1'b1;
          end else begin
            wr_ptr_d = commit_ptr_q;
            drop_inc = 1'b1;
          end
          state_d = W_IDLE;
        end
      end
      W_DROP: begin
        if (!bus.udp_rec_data_valid) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d        = rd_ptr_q;
    rd_rem_d        = rd_rem_q;
    rd_data_d       = rd_data_q;
    rd_data_valid_d = rd_accept;
    rd_last_d       = rd_final;
    blank_d         = fifo_pop;
    fifo_wp_d       = fifo_push ? fifo_wp_q + fptr_t'(1) : fifo_wp_q;
    fifo_rp_d       = fifo_pop  ? fifo_rp_q + fptr_t'(1) : fifo_rp_q;
    ok_cnt_d        = ok_inc   ? sat_inc(ok_cnt_q)   : ok_cnt_q;
    drop_cnt_d      = drop_inc ? sat_inc(drop_cnt_q) : drop_cnt_q;
    if (rd_accept) begin
      rd_ptr_d  = rd_ptr_q + ptr_t'(1);
      rd_data_d = buf_mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      rd_rem_d  = rd_final ? 16'd0 : rd_rem_q + 16'd1;
    end
  end

  // NOTE: storage arrays carry no reset; validity is tracked entirely by the
  // pointers, and a reset port would keep them out of block RAM.
  always_ff @(posedge rgmii_clk) begin
    if (buf_we)    buf_mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.udp_rec_rdata;
    if (fifo_push) len_fifo[fifo_wp_q[LFW-1:0]]      <= len_q;
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its _d value from the same pre-edge snapshot.
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      state_q         <= W_IDLE;
      wr_ptr_q        <= '0;
      commit_ptr_q    <= '0;
      rd_ptr_q        <= '0;
      len_q           <= '0;
      wr_cnt_q        <= '0;
      fifo_wp_q       <= '0;
      fifo_rp_q       <= '0;
      rd_rem_q        <= '0;
      blank_q         <= 1'b0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
      rd_last_q       <= 1'b0;
      ok_cnt_q        <= '0;
      drop_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      commit_ptr_q    <= commit_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      len_q           <= len_d;
      wr_cnt_q        <= wr_cnt_d;
      fifo_wp_q       <= fifo_wp_d;
      fifo_rp_q       <= fifo_rp_d;
      rd_rem_q        <= rd_rem_d;
      blank_q         <= blank_d;
      rd_data_q       <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
      rd_last_q       <= rd_last_d;
      ok_cnt_q        <= ok_cnt_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  assign bus.rd_pkt_avail  = pkt_avail;
  assign bus.rd_pkt_len    = pkt_avail ? head_len : 16'd0;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_data_valid_q;
  assign bus.rd_last       = rd_last_q;
  assign pkt_ok_cnt        = ok_cnt_q;
  assign pkt_drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_eth_udp_rx_sink.sv
// Randomized bench for eth_udp_rx_sink against a packet-level queue model
// (committed bytes in one FIFO, committed lengths in another).
module tb_eth_udp_rx_sink;
  localparam int          AW      = 6;
  localparam int          BUF_B   = 1 << AW;
  localparam logic [15:0] MAXL    = 16'd48;
  localparam int          NDESC   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_udp_rx_sink_if bus_if();
  logic [15:0] pkt_ok_cnt, pkt_drop_cnt;

  eth_udp_rx_sink #(
    .ADDR_WIDTH(AW), .MAX_PKT_LEN(MAXL), .LEN_FIFO_DEPTH(NDESC)
  ) dut (
    .rgmii_clk   (clk),
    .rst         (rst),
    .bus         (bus_if),
    .pkt_ok_cnt  (pkt_ok_cnt),
    .pkt_drop_cnt(pkt_drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes committed and not yet requested, lengths of
  // committed packets not yet fully requested, and the pending read response.
  logic [7:0] stored[$];
  int         lens[$];
  int         head_done;
  bit         blank;
  bit         pend_dv;
  bit         pend_last;
  logic [7:0] pend_data;
  int         exp_ok, exp_drop;
  int         rd_policy;
  logic [7:0] burst[$];
  string      msg;

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_clear();
    stored.delete();
    lens.delete();
    head_done = 0;
    blank     = 1'b0;
    pend_dv   = 1'b0;
    pend_last = 1'b0;
    pend_data = '0;
    exp_ok    = 0;
    exp_drop  = 0;
  endtask

  // One clock: check outputs of the previous edge, drive inputs, advance the read model.
  task automatic step_cycle(input logic v, input logic [7:0] d, input logic [15:0] l);
    bit re, av;
    @(negedge clk);
    av = (lens.size() > 0) && !blank;
    check("avail", bus_if.rd_pkt_avail, av);
    if (av) check("pkt_len", bus_if.rd_pkt_len, lens[0]);
    check("data_valid", bus_if.rd_data_valid, pend_dv);
    check("last", bus_if.rd_last, pend_last);
    if (pend_dv) check("data", bus_if.rd_data, pend_data);
    check("ok_cnt", pkt_ok_cnt, exp_ok);
    check("drop_cnt", pkt_drop_cnt, exp_drop);

    re = (rd_policy == 1) || (rd_policy == 2 && $urandom_range(0, 1) == 1);
    bus_if.udp_rec_data_valid  = v;
    bus_if.udp_rec_rdata       = d;
    bus_if.udp_rec_data_length = l;
    bus_if.rd_en               = re;

    pend_dv   = 1'b0;
    pend_last = 1'b0;
    blank     = 1'b0;
    if (re && av) begin
      pend_dv   = 1'b1;
      pend_data = stored.pop_front();
      head_done++;
      if (head_done == lens[0]) begin
        pend_last = 1'b1;
        void'(lens.pop_front());
        head_done = 0;
        blank     = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step_cycle(1'b0, 8'h00, 16'h0000);
  endtask

  // Sends one burst of nbytes with the given length field, then one gap cycle.
  task automatic send_pkt(input int len_field, input int nbytes, input bit use_msg);
    bit acc, dropped;
    burst.delete();
    for (int i = 0; i < nbytes; i++)
      burst.push_back(use_msg ? 8'(msg[i]) : 8'($urandom));
    acc = (len_field != 0) && (len_field <= int'(MAXL)) &&
          (len_field <= BUF_B - stored.size()) && (lens.size() < NDESC);
    dropped = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      step_cycle(1'b1, burst[i], 16'(len_field));
      if (i == 0 && !acc) exp_drop = sat(exp_drop);
      if (acc && !dropped && i == len_field) begin
        exp_drop = sat(exp_drop);
        dropped  = 1'b1;
      end
    end
    step_cycle(1'b0, 8'h00, 16'h0000);
    if (acc && !dropped) begin
      if (nbytes == len_field) begin
        exp_ok = sat(exp_ok);
        foreach (burst[i]) stored.push_back(burst[i]);
        lens.push_back(len_field);
      end else begin
        exp_drop = sat(exp_drop);
      end
    end
  endtask

  task automatic drain();
    rd_policy = 1;
    for (int k = 0; k < 3000 && (lens.size() > 0 || pend_dv); k++) step_cycle(1'b0, 8'h00, 16'h0000);
    rd_policy = 0;
    idle(1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_if.udp_rec_data_valid = 1'b0;
    bus_if.rd_en              = 1'b0;
    @(negedge clk);
    check("rst_avail", bus_if.rd_pkt_avail, 0);
    check("rst_pkt_len", bus_if.rd_pkt_len, 0);
    check("rst_data_valid", bus_if.rd_data_valid, 0);
    check("rst_last", bus_if.rd_last, 0);
    check("rst_data", bus_if.rd_data, 0);
    check("rst_ok_cnt", pkt_ok_cnt, 0);
    check("rst_drop_cnt", pkt_drop_cnt, 0);
    model_clear();
    rst = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, nb, kind;
    bus_if.udp_rec_data_valid  = 1'b0;
    bus_if.udp_rec_rdata       = 8'h00;
    bus_if.udp_rec_data_length = 16'h0000;
    bus_if.rd_en               = 1'b0;
    rd_policy = 0;
    msg = "www.meyesemi.com   \n";
    model_clear();
    reset_dut();

    // Reference message: committed, then read back with rd_last on byte 20.
    send_pkt(20, 20, 1'b1);
    idle(2);
    drain();

    // Short packet dropped, following full packet accepted.
    send_pkt(20, 15, 1'b0);
    idle(1);
    send_pkt(20, 20, 1'b0);
    drain();

    // Overlong, zero-length, over-limit lengths; exact-limit length accepted.
    send_pkt(21, 22, 1'b0);
    send_pkt(0, 1, 1'b0);
    send_pkt(int'(MAXL) + 1, int'(MAXL) + 1, 1'b0);
    send_pkt(1473, 4, 1'b0);
    send_pkt(int'(MAXL), int'(MAXL), 1'b0);
    drain();

    // Buffer-space limit and wrap across the end of the buffer.
    repeat (3) send_pkt(20, 20, 1'b0);
    send_pkt(20, 20, 1'b0);
    rd_policy = 1;
    for (int k = 0; k < 100 && lens.size() > 2; k++) step_cycle(1'b0, 8'h00, 16'h0000);
    rd_policy = 0;
    idle(2);
    send_pkt(20, 20, 1'b0);
    drain();

    // Descriptor FIFO full, then reading while new packets arrive.
    repeat (5) send_pkt(8, 8, 1'b0);
    rd_policy = 1;
    repeat (8) send_pkt(8, 8, 1'b0);
    drain();

    // Randomized traffic with random read pressure.
    repeat (250) begin
      kind = $urandom_range(0, 9);
      if (kind < 7) begin
        len = $urandom_range(1, int'(MAXL));
        nb  = len;
      end else if (kind == 7) begin
        len = $urandom_range(2, int'(MAXL));
        nb  = $urandom_range(1, len + 3);
      end else if (kind == 8) begin
        len = 0;
        nb  = $urandom_range(1, 3);
      end else begin
        len = ($urandom_range(0, 1) == 1) ? int'(MAXL) + $urandom_range(1, 20) : 1473;
        nb  = $urandom_range(1, 5);
      end
      rd_policy = $urandom_range(0, 2);
      send_pkt(len, nb, 1'b0);
      idle($urandom_range(0, 2));
    end
    drain();

    // Reset in the middle of a burst with two packets stored.
    send_pkt(10, 10, 1'b0);
    send_pkt(10, 10, 1'b0);
    for (int i = 0; i < 6; i++) step_cycle(1'b1, 8'($urandom), 16'd20);
    reset_dut();
    idle(2);
    send_pkt(12, 12, 1'b0);
    idle(1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
